// File: rtl/readout_framer_if.sv
// Output word stream of the readout framer: framed word plus valid/ready handshake.
interface readout_framer_if;
    logic [15:0] DOUT;
    logic        DOUT_VALID;
    logic        DOUT_READY;

    modport master (output DOUT, output DOUT_VALID, input DOUT_READY);
    modport slave  (input DOUT, input DOUT_VALID, output DOUT_READY);
endinterface

// File: rtl/readout_framer.sv
// Frames serial TBM/ROC packets into typed 16-bit words behind a 4-entry FIFO.
// Define FRAMER_TIMEOUT_EN to add a 10-bit watchdog that force-closes stalled events.
module readout_framer (
    input  logic             CLK,
    input  logic             RES_N,
    input  logic             SDI,
    input  logic             TBM_HEADER,
    input  logic             ROC_HEADER,
    input  logic             TBM_TRAILER,
    input  logic             GATE,
    readout_framer_if.master dout,
    output logic [7:0]       EVT_WORDS,
    output logic             EVT_DONE,
    output logic             OVERFLOW,
    output logic [7:0]       BIT_ERR
);

    typedef enum logic [1:0] {StIdle, StTbmh, StRocd, StTbmt} state_e;

    state_e      state_q, state_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    // The 12th bit completes a word straight from SDI, so 11 stored bits suffice.
    logic [10:0] shift_q, shift_d;
    logic        word_idx_q, word_idx_d;
    logic        roc_act_q, roc_act_d;
    logic        roc_first_q, roc_first_d;
    logic [7:0]  evt_cnt_q, evt_cnt_d;
    logic [7:0]  evt_words_q, evt_words_d;
    logic        evt_done_q, evt_done_d;
    logic        overflow_q, overflow_d;
    logic [7:0]  bit_err_q, bit_err_d;

    logic [15:0] mem_q [4];
    logic [1:0]  wr_ptr_q, rd_ptr_q;
    logic [2:0]  count_q;

    logic        collect, word_done, partial, trunc, evt_clear;
    logic [11:0] shifted;
    logic        wr_en, wr_ok, rd_en, full;
    logic [15:0] wr_data;

`ifdef FRAMER_TIMEOUT_EN
    logic [9:0]  wd_q, wd_d;
    logic        any_marker, in_win;
`endif

    assign full  = (count_q == 3'd4);
    assign rd_en = (count_q != 3'd0) && dout.DOUT_READY;
    assign wr_ok = wr_en && (!full || rd_en);

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        word_idx_d  = word_idx_q;
        roc_act_d   = roc_act_q;
        roc_first_d = roc_first_q;
        evt_done_d  = 1'b0;
        evt_clear   = 1'b0;
        trunc       = 1'b0;
        wr_en       = 1'b0;
        wr_data     = 16'h0000;

        collect   = (state_q == StTbmh) || (state_q == StTbmt) ||
                    ((state_q == StRocd) && roc_act_q);
        shifted   = {shift_q, SDI};
        word_done = collect && (bit_cnt_q == 4'd11);
        partial   = collect && !word_done && (state_q == StRocd);

        if (collect) begin
            shift_d   = shifted[10:0];
            bit_cnt_d = word_done ? 4'd0 : bit_cnt_q + 4'd1;
        end

        if (word_done) begin
            wr_en = 1'b1;
            unique case (state_q)
                StTbmh: begin
                    wr_data    = {(word_idx_q ? 4'h9 : 4'h8), shifted};
                    word_idx_d = ~word_idx_q;
                    if (word_idx_q) begin
                        state_d   = StRocd;
                        roc_act_d = 1'b0;
                    end
                end
                StTbmt: begin
                    wr_data    = {(word_idx_q ? 4'hF : 4'hE), shifted};
                    word_idx_d = ~word_idx_q;
                    if (word_idx_q) begin
                        state_d    = StIdle;
                        evt_done_d = 1'b1;
                    end
                end
                StRocd: begin
                    wr_data     = {(roc_first_q ? 4'h4 : 4'h0), shifted};
                    roc_first_d = 1'b0;
                end
                default: ;
            endcase
        end

        // Markers act on the state reached after any word completed this cycle.
        if (TBM_HEADER) begin
            trunc      = partial;
            state_d    = StTbmh;
            bit_cnt_d  = 4'd0;
            word_idx_d = 1'b0;
            roc_act_d  = 1'b0;
            evt_clear  = 1'b1;
        end else if (TBM_TRAILER && ((state_d == StTbmh) || (state_d == StRocd))) begin
            trunc      = partial;
            state_d    = StTbmt;
            bit_cnt_d  = 4'd0;
            word_idx_d = 1'b0;
            roc_act_d  = 1'b0;
        end else if (ROC_HEADER && GATE && (state_d == StRocd)) begin
            trunc       = partial;
            bit_cnt_d   = 4'd0;
            roc_act_d   = 1'b1;
            roc_first_d = 1'b1;
        end

`ifdef FRAMER_TIMEOUT_EN
        any_marker = TBM_HEADER || ROC_HEADER || TBM_TRAILER;
        in_win     = (state_q == StTbmh) || (state_q == StRocd);
        wd_d       = (in_win && !any_marker) ? wd_q + 10'd1 : 10'd0;
        if (in_win && !any_marker && (wd_q == 10'h3FF)) begin
            wr_en      = 1'b1;
            wr_data    = 16'hF000;
            state_d    = StIdle;
            evt_done_d = 1'b1;
            bit_cnt_d  = 4'd0;
            roc_act_d  = 1'b0;
            wd_d       = 10'd0;
        end
`endif

        bit_err_d = (trunc && (bit_err_q != 8'hFF)) ? bit_err_q + 8'd1 : bit_err_q;

        if (evt_clear) begin
            evt_cnt_d = 8'd0;
        end else if (wr_ok && (evt_cnt_q != 8'hFF)) begin
            evt_cnt_d = evt_cnt_q + 8'd1;
        end else begin
            evt_cnt_d = evt_cnt_q;
        end

        evt_words_d = evt_words_q;
        if (evt_done_d) begin
            evt_words_d = (wr_ok && (evt_cnt_q != 8'hFF)) ? evt_cnt_q + 8'd1 : evt_cnt_q;
        end

        overflow_d = overflow_q || (wr_en && full && !rd_en);
    end

    always_ff @(posedge CLK or negedge RES_N) begin
        if (!RES_N) begin
            state_q     <= StIdle;
            bit_cnt_q   <= 4'd0;
            shift_q     <= 11'd0;
            word_idx_q  <= 1'b0;
            roc_act_q   <= 1'b0;
            roc_first_q <= 1'b0;
            evt_cnt_q   <= 8'd0;
            evt_words_q <= 8'd0;
            evt_done_q  <= 1'b0;
            overflow_q  <= 1'b0;
            bit_err_q   <= 8'd0;
`ifdef FRAMER_TIMEOUT_EN
            wd_q        <= 10'd0;
`endif
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            word_idx_q  <= word_idx_d;
            roc_act_q   <= roc_act_d;
            roc_first_q <= roc_first_d;
            evt_cnt_q   <= evt_cnt_d;
            evt_words_q <= evt_words_d;
            evt_done_q  <= evt_done_d;
            overflow_q  <= overflow_d;
            bit_err_q   <= bit_err_d;
`ifdef FRAMER_TIMEOUT_EN
            wd_q        <= wd_d;
`endif
        end
    end

    always_ff @(posedge CLK or negedge RES_N) begin
        if (!RES_N) begin
            for (int i = 0; i < 4; i++) begin
                mem_q[i] <= 16'h0000;
            end
            wr_ptr_q <= 2'd0;
            rd_ptr_q <= 2'd0;
            count_q  <= 3'd0;
        end else begin
            if (wr_ok) begin
                mem_q[wr_ptr_q] <= wr_data;
                wr_ptr_q        <= wr_ptr_q + 2'd1;
            end
            if (rd_en) begin
                rd_ptr_q <= rd_ptr_q + 2'd1;
            end
            count_q <= count_q + {2'b00, wr_ok} - {2'b00, rd_en};
        end
    end

    assign dout.DOUT       = (count_q != 3'd0) ? mem_q[rd_ptr_q] : 16'h0000;
    assign dout.DOUT_VALID = (count_q != 3'd0);
    assign EVT_WORDS       = evt_words_q;
    assign EVT_DONE        = evt_done_q;
    assign OVERFLOW        = overflow_q;
    assign BIT_ERR         = bit_err_q;

endmodule

// File: tb/tb_readout_framer.sv
// Directed bench for readout_framer: events, payload order, back-pressure, truncation,
// gate qualifier, reset and the FRAMER_TIMEOUT_EN watchdog.
module tb_readout_framer;

    logic       CLK = 1'b0;
    logic       RES_N = 1'b0;
    logic       SDI = 1'b0;
    logic       TBM_HEADER = 1'b0;
    logic       ROC_HEADER = 1'b0;
    logic       TBM_TRAILER = 1'b0;
    logic       GATE = 1'b1;
    logic [7:0] EVT_WORDS;
    logic       EVT_DONE;
    logic       OVERFLOW;
    logic [7:0] BIT_ERR;

    readout_framer_if bus ();

    readout_framer dut (
        .CLK         (CLK),
        .RES_N       (RES_N),
        .SDI         (SDI),
        .TBM_HEADER  (TBM_HEADER),
        .ROC_HEADER  (ROC_HEADER),
        .TBM_TRAILER (TBM_TRAILER),
        .GATE        (GATE),
        .dout        (bus),
        .EVT_WORDS   (EVT_WORDS),
        .EVT_DONE    (EVT_DONE),
        .OVERFLOW    (OVERFLOW),
        .BIT_ERR     (BIT_ERR)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_err = 0;
    logic [15:0] got [$];
    int done_cnt = 0;

    // Transfers and done pulses are sampled on the falling edge, away from the active edge.
    always @(negedge CLK) begin
        if (RES_N && bus.DOUT_VALID && bus.DOUT_READY) got.push_back(bus.DOUT);
        if (EVT_DONE) done_cnt++;
    end

    task automatic tick(input logic sdi, input logic th, input logic rh, input logic tt);
        SDI = sdi;
        TBM_HEADER = th;
        ROC_HEADER = rh;
        TBM_TRAILER = tt;
        @(posedge CLK);
        #1;
        SDI = 1'b0;
        TBM_HEADER = 1'b0;
        ROC_HEADER = 1'b0;
        TBM_TRAILER = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) tick(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Sends 12 bits MSB first; the given markers pulse together with bit index mpos.
    task automatic send_word(input logic [11:0] w, input int mpos,
                             input logic th, input logic rh, input logic tt);
        for (int i = 0; i < 12; i++) begin
            tick(w[11-i], (i == mpos) ? th : 1'b0, (i == mpos) ? rh : 1'b0,
                 (i == mpos) ? tt : 1'b0);
        end
    endtask

    task automatic begin_event(input logic [11:0] w1, input logic [11:0] w2, input logic rh_last);
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        send_word(w1, 11, 1'b0, 1'b0, 1'b0);
        send_word(w2, 11, 1'b0, rh_last, 1'b0);
    endtask

    task automatic test_reset;
        RES_N = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        n_cmp++; if (bus.DOUT !== 16'h0000) begin n_err++; $display("FAIL reset_dout: got %h want 0000", bus.DOUT); end
        n_cmp++; if (bus.DOUT_VALID !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", bus.DOUT_VALID); end
        n_cmp++; if (EVT_WORDS !== 8'd0) begin n_err++; $display("FAIL reset_evt_words: got %0d want 0", EVT_WORDS); end
        n_cmp++; if (EVT_DONE !== 1'b0) begin n_err++; $display("FAIL reset_evt_done: got %b want 0", EVT_DONE); end
        n_cmp++; if (OVERFLOW !== 1'b0) begin n_err++; $display("FAIL reset_overflow: got %b want 0", OVERFLOW); end
        n_cmp++; if (BIT_ERR !== 8'd0) begin n_err++; $display("FAIL reset_bit_err: got %0d want 0", BIT_ERR); end
        RES_N = 1'b1;
        idle(2);
    endtask

    task automatic test_full_event;
        logic [15:0] exp [7] = '{16'h8A01, 16'h9B02, 16'h4C03, 16'h0D04, 16'h0E05,
                                 16'hE123, 16'hF456};
        int base = got.size();
        int dbase = done_cnt;
        begin_event(12'hA01, 12'hB02, 1'b1);
        send_word(12'hC03, 11, 1'b0, 1'b0, 1'b0);
        send_word(12'hD04, 11, 1'b0, 1'b0, 1'b0);
        send_word(12'hE05, 11, 1'b0, 1'b0, 1'b1);
        send_word(12'h123, 11, 1'b0, 1'b0, 1'b0);
        send_word(12'h456, 11, 1'b0, 1'b0, 1'b0);
        idle(4);
        n_cmp++; if (got.size() - base != 7) begin n_err++; $display("FAIL full_count: got %0d want 7", got.size() - base); end
        for (int i = 0; i < 7; i++) begin
            n_cmp++;
            if (base + i >= got.size()) begin
                n_err++; $display("FAIL full_word%0d: got none want %h", i, exp[i]);
            end else if (got[base+i] !== exp[i]) begin
                n_err++; $display("FAIL full_word%0d: got %h want %h", i, got[base+i], exp[i]);
            end
        end
        n_cmp++; if (done_cnt - dbase != 1) begin n_err++; $display("FAIL full_done: got %0d want 1", done_cnt - dbase); end
        n_cmp++; if (EVT_WORDS !== 8'd7) begin n_err++; $display("FAIL full_evt_words: got %0d want 7", EVT_WORDS); end
        n_cmp++; if (BIT_ERR !== 8'd0) begin n_err++; $display("FAIL full_bit_err: got %0d want 0", BIT_ERR); end
    endtask

    task automatic test_payload;
        int base = got.size();
        begin_event(12'h111, 12'h222, 1'b1);
        send_word(12'b1010_1100_0011, 11, 1'b0, 1'b0, 1'b1);
        send_word(12'h333, 11, 1'b0, 1'b0, 1'b0);
        send_word(12'h444, 11, 1'b0, 1'b0, 1'b0);
        idle(4);
        n_cmp++;
        if (base + 2 >= got.size()) begin
            n_err++; $display("FAIL payload_word: got none want 4ac3");
        end else if (got[base+2] !== 16'h4AC3) begin
            n_err++; $display("FAIL payload_word: got %h want 4ac3", got[base+2]);
        end
        n_cmp++; if (EVT_WORDS !== 8'd5) begin n_err++; $display("FAIL payload_evt_words: got %0d want 5", EVT_WORDS); end
    endtask

    task automatic test_truncation;
        logic [15:0] exp [6] = '{16'h8AAA, 16'h9BBB, 16'h4111, 16'h4222, 16'hE333, 16'hF444};
        int base = got.size();
        begin_event(12'hAAA, 12'hBBB, 1'b1);
        send_word(12'h111, 11, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b1, 1'b0);
        send_word(12'h222, 11, 1'b0, 1'b0, 1'b1);
        send_word(12'h333, 11, 1'b0, 1'b0, 1'b0);
        send_word(12'h444, 11, 1'b0, 1'b0, 1'b0);
        idle(4);
        n_cmp++; if (BIT_ERR !== 8'd1) begin n_err++; $display("FAIL trunc_bit_err: got %0d want 1", BIT_ERR); end
        n_cmp++; if (got.size() - base != 6) begin n_err++; $display("FAIL trunc_count: got %0d want 6", got.size() - base); end
        for (int i = 0; i < 6; i++) begin
            n_cmp++;
            if (base + i >= got.size()) begin
                n_err++; $display("FAIL trunc_word%0d: got none want %h", i, exp[i]);
            end else if (got[base+i] !== exp[i]) begin
                n_err++; $display("FAIL trunc_word%0d: got %h want %h", i, got[base+i], exp[i]);
            end
        end
    endtask

    task automatic test_gate;
        logic [15:0] exp [6] = '{16'h8555, 16'h9666, 16'h4333, 16'h0444, 16'hE777, 16'hF888};
        int base = got.size();
        begin_event(12'h555, 12'h666, 1'b1);
        GATE = 1'b0;
        send_word(12'h333, 6, 1'b0, 1'b1, 1'b0);
        GATE = 1'b1;
        send_word(12'h444, 11, 1'b0, 1'b0, 1'b1);
        send_word(12'h777, 11, 1'b0, 1'b0, 1'b0);
        send_word(12'h888, 11, 1'b0, 1'b0, 1'b0);
        idle(4);
        n_cmp++; if (BIT_ERR !== 8'd1) begin n_err++; $display("FAIL gate_bit_err: got %0d want 1", BIT_ERR); end
        n_cmp++; if (got.size() - base != 6) begin n_err++; $display("FAIL gate_count: got %0d want 6", got.size() - base); end
        for (int i = 0; i < 6; i++) begin
            n_cmp++;
            if (base + i >= got.size()) begin
                n_err++; $display("FAIL gate_word%0d: got none want %h", i, exp[i]);
            end else if (got[base+i] !== exp[i]) begin
                n_err++; $display("FAIL gate_word%0d: got %h want %h", i, got[base+i], exp[i]);
            end
        end
    endtask

    task automatic test_back_pressure;
        logic [15:0] exp [4] = '{16'h8121, 16'h9232, 16'h4343, 16'h0454};
        int base;
        int dbase = done_cnt;
        bus.DOUT_READY = 1'b0;
        begin_event(12'h121, 12'h232, 1'b1);
        send_word(12'h343, 11, 1'b0, 1'b0, 1'b0);
        send_word(12'h454, 11, 1'b0, 1'b0, 1'b1);
        send_word(12'h565, 11, 1'b0, 1'b0, 1'b0);
        send_word(12'h676, 11, 1'b0, 1'b0, 1'b0);
        idle(3);
        n_cmp++; if (bus.DOUT_VALID !== 1'b1) begin n_err++; $display("FAIL bp_valid: got %b want 1", bus.DOUT_VALID); end
        n_cmp++; if (bus.DOUT !== 16'h8121) begin n_err++; $display("FAIL bp_head: got %h want 8121", bus.DOUT); end
        n_cmp++; if (OVERFLOW !== 1'b1) begin n_err++; $display("FAIL bp_overflow: got %b want 1", OVERFLOW); end
        n_cmp++; if (EVT_WORDS !== 8'd4) begin n_err++; $display("FAIL bp_evt_words: got %0d want 4", EVT_WORDS); end
        n_cmp++; if (done_cnt - dbase != 1) begin n_err++; $display("FAIL bp_done: got %0d want 1", done_cnt - dbase); end
        base = got.size();
        bus.DOUT_READY = 1'b1;
        idle(8);
        n_cmp++; if (got.size() - base != 4) begin n_err++; $display("FAIL bp_count: got %0d want 4", got.size() - base); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (base + i >= got.size()) begin
                n_err++; $display("FAIL bp_word%0d: got none want %h", i, exp[i]);
            end else if (got[base+i] !== exp[i]) begin
                n_err++; $display("FAIL bp_word%0d: got %h want %h", i, got[base+i], exp[i]);
            end
        end
        n_cmp++; if (OVERFLOW !== 1'b1) begin n_err++; $display("FAIL bp_sticky: got %b want 1", OVERFLOW); end
    endtask

    task automatic test_reset_mid_rocd;
        int base;
        int dbase;
        bus.DOUT_READY = 1'b0;
        begin_event(12'h9A9, 12'h8B8, 1'b1);
        repeat (5) tick(1'b1, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (bus.DOUT_VALID !== 1'b1) begin n_err++; $display("FAIL mid_pre_valid: got %b want 1", bus.DOUT_VALID); end
        RES_N = 1'b0;
        #1;
        n_cmp++; if (bus.DOUT !== 16'h0000) begin n_err++; $display("FAIL mid_dout: got %h want 0000", bus.DOUT); end
        n_cmp++; if (bus.DOUT_VALID !== 1'b0) begin n_err++; $display("FAIL mid_valid: got %b want 0", bus.DOUT_VALID); end
        n_cmp++; if (EVT_WORDS !== 8'd0) begin n_err++; $display("FAIL mid_evt_words: got %0d want 0", EVT_WORDS); end
        n_cmp++; if (EVT_DONE !== 1'b0) begin n_err++; $display("FAIL mid_evt_done: got %b want 0", EVT_DONE); end
        n_cmp++; if (OVERFLOW !== 1'b0) begin n_err++; $display("FAIL mid_overflow: got %b want 0", OVERFLOW); end
        n_cmp++; if (BIT_ERR !== 8'd0) begin n_err++; $display("FAIL mid_bit_err: got %0d want 0", BIT_ERR); end
        repeat (2) @(posedge CLK);
        #1;
        bus.DOUT_READY = 1'b1;
        RES_N = 1'b1;
        base = got.size();
        dbase = done_cnt;
        // Back in IDLE, ROC data and a trailer without a TBM header must be ignored.
        send_word(12'h7C7, 11, 1'b0, 1'b0, 1'b1);
        send_word(12'h6D6, 11, 1'b0, 1'b0, 1'b0);
        send_word(12'h5E5, 11, 1'b0, 1'b0, 1'b0);
        idle(4);
        n_cmp++; if (got.size() - base != 0) begin n_err++; $display("FAIL mid_no_words: got %0d want 0", got.size() - base); end
        n_cmp++; if (done_cnt - dbase != 0) begin n_err++; $display("FAIL mid_no_done: got %0d want 0", done_cnt - dbase); end
        n_cmp++; if (BIT_ERR !== 8'd0) begin n_err++; $display("FAIL mid_post_bit_err: got %0d want 0", BIT_ERR); end
    endtask

    task automatic test_timeout;
        int base = got.size();
        int dbase = done_cnt;
        begin_event(12'h0F1, 12'h0E2, 1'b0);
        idle(1100);
        n_cmp++;
        if (base + 1 >= got.size()) begin
            n_err++; $display("FAIL to_tbm_words: got %0d words want at least 2", got.size() - base);
        end else if (got[base] !== 16'h80F1 || got[base+1] !== 16'h90E2) begin
            n_err++; $display("FAIL to_tbm_words: got %h %h want 80f1 90e2", got[base], got[base+1]);
        end
`ifdef FRAMER_TIMEOUT_EN
        n_cmp++; if (got.size() - base != 3) begin n_err++; $display("FAIL to_count: got %0d want 3", got.size() - base); end
        n_cmp++;
        if (base + 2 >= got.size()) begin
            n_err++; $display("FAIL to_word: got none want f000");
        end else if (got[base+2] !== 16'hF000) begin
            n_err++; $display("FAIL to_word: got %h want f000", got[base+2]);
        end
        n_cmp++; if (done_cnt - dbase != 1) begin n_err++; $display("FAIL to_done: got %0d want 1", done_cnt - dbase); end
        n_cmp++; if (EVT_WORDS !== 8'd3) begin n_err++; $display("FAIL to_evt_words: got %0d want 3", EVT_WORDS); end
`else
        n_cmp++; if (got.size() - base != 2) begin n_err++; $display("FAIL to_count: got %0d want 2", got.size() - base); end
        n_cmp++; if (done_cnt - dbase != 0) begin n_err++; $display("FAIL to_done: got %0d want 0", done_cnt - dbase); end
`endif
    endtask

    initial begin
        bus.DOUT_READY = 1'b1;
        test_reset();
        test_full_event();
        test_payload();
        test_truncation();
        test_gate();
        test_back_pressure();
        test_reset_mid_rocd();
        test_timeout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/readout_framer.md
READOUT_FRAMER -- requirements
Module: readout_framer

Interface
REQ-001 CLK  input  1  sole clock; all state updates on posedge CLK.
REQ-002 RES_N  input  1  reset, asynchronous, active-low.
REQ-003 SDI  input  1  serial data from the header/trailer detector's delayed data output.
REQ-004 TBM_HEADER, ROC_HEADER, TBM_TRAILER  input  1 each  single-cycle marker pulses from the detector.
REQ-005 GATE  input  1  event gate from the detector; high between TBM header and TBM trailer.
REQ-006 DOUT  output  16  framed word {type[3:0], payload[11:0]}.
REQ-007 DOUT_VALID  output  1  DOUT holds a word.
REQ-008 DOUT_READY  input  1  consumer accepts DOUT this cycle.
REQ-009 EVT_WORDS  output  8  words written for the last completed event, saturating at 255.
REQ-010 EVT_DONE  output  1  one-cycle pulse when an event closes.
REQ-011 OVERFLOW  output  1  sticky: a word was dropped because the FIFO was full.
REQ-012 BIT_ERR  output  8  count of truncated ROC words, saturating at 255.

Function
REQ-013 The first packet bit is on SDI one cycle after a marker pulse; the SDI bit in the marker cycle still belongs to the previous packet.
REQ-014 States: IDLE, TBMH, ROCD, TBMT; a 4-bit bit counter (0..11) and a 12-bit shift register (MSB first) are used in all states except IDLE.
REQ-015 IDLE -> TBMH on TBM_HEADER; all other markers and SDI are ignored in IDLE.
REQ-016 TBMH: collect 2 words, types 0x8 then 0x9; then go to ROCD, waiting with the counter held at 0.
REQ-017 ROCD: ROC_HEADER with GATE=1 restarts collection; the first word has type 0x4 and each following 12-bit word has type 0x0, until the next marker.
REQ-018 A ROC_HEADER with GATE=0 is ignored.
REQ-019 TBM_TRAILER in TBMH or ROCD -> TBMT; collect 2 words, types 0xE then 0xF; then go to IDLE and pulse EVT_DONE.
REQ-020 TBM_HEADER in any non-IDLE state restarts TBMH; the current event closes without EVT_DONE.
REQ-021 A word is written when the 12th bit is shifted in; the counter then wraps to 0.
REQ-022 If a marker arrives in ROCD with a nonzero counter after the marker-cycle bit, the partial word is discarded and BIT_ERR increments.
REQ-023 If the 12th bit and a marker fall in the same cycle, the word is written first, then the marker is acted on, with no BIT_ERR.
REQ-024 Output FIFO: 4 entries; a word transfers when DOUT_VALID && DOUT_READY.
REQ-025 Simultaneous FIFO write and read are both performed.
REQ-026 A write to a full FIFO with no read in the same cycle drops the word and sets OVERFLOW.
REQ-027 Latency: a word is visible on DOUT one cycle after its 12th bit when the FIFO is empty.
REQ-028 A per-event counter counts FIFO writes from TBMH entry.
REQ-029 The per-event counter is copied to EVT_WORDS in the EVT_DONE cycle; dropped words are not counted.

Reset
REQ-030 RES_N low: state IDLE, counters 0, FIFO empty, DOUT=0x0000, DOUT_VALID=0, EVT_WORDS=0, EVT_DONE=0, OVERFLOW=0, BIT_ERR=0.
REQ-031 Reset mid-event discards all partial and buffered data; no EVT_DONE follows.
REQ-032 Release is synchronous-safe: the first posedge after RES_N rises sees IDLE.

Configuration
REQ-033 Macro FRAMER_TIMEOUT_EN defined: a 10-bit watchdog counts cycles in TBMH/ROCD without a marker.
REQ-034 With FRAMER_TIMEOUT_EN, on reaching 1023 the block writes a synthetic word 0xF000, goes to IDLE and pulses EVT_DONE.
REQ-035 FRAMER_TIMEOUT_EN undefined: no watchdog logic; an event remains open until TBM_TRAILER, TBM_HEADER or reset.

Verification
REQ-036 Full event: TBM_HEADER + 24 bits, ROC_HEADER + 36 bits, TBM_TRAILER + 24 bits, DOUT_READY=1 -> words typed 0x8,0x9,0x4,0x0,0x0,0xE,0xF; EVT_WORDS=7; one EVT_DONE.
REQ-037 Payload order: bits 1010_1100_0011 after ROC_HEADER -> DOUT=0x4AC3.
REQ-038 Back-pressure: DOUT_READY=0 across 6 words -> first 4 held in order, OVERFLOW=1, EVT_WORDS counts 4.
REQ-039 Truncation: ROC_HEADER 5 cycles after a word boundary in ROCD -> BIT_ERR=1, no partial word emitted.
REQ-040 Gate qualifier and reset: ROC_HEADER with GATE=0 -> no state change; RES_N low mid-ROCD -> all outputs at reset values.
REQ-041 FRAMER_TIMEOUT_EN build: TBM_HEADER then 1100 idle cycles -> 0x8, 0x9, 0xF000, EVT_DONE; non-timeout build -> no 0xF000.
